// File: rtl/wb_trace_pkg.sv
// Shared encodings and entry layout helpers for the writeback trace buffer.
package wb_trace_pkg;

    localparam int unsigned ST_W    = 3;
    localparam int unsigned RD_W    = 5;
    localparam int unsigned FLAGS_W = 5;

    localparam logic [ST_W-1:0] ST_IDLE    = 3'd0;
    localparam logic [ST_W-1:0] ST_CAPTURE = 3'd1;
    localparam logic [ST_W-1:0] ST_POST    = 3'd2;
    localparam logic [ST_W-1:0] ST_DONE    = 3'd3;
    localparam logic [ST_W-1:0] ST_READOUT = 3'd4;

    // Per-channel field: {rd, flags, data}, data in the LSBs
    function automatic int unsigned ch_field_w(input int unsigned data_w);
        return RD_W + FLAGS_W + data_w;
    endfunction

    function automatic int unsigned ch_lsb(input int unsigned ch, input int unsigned data_w);
        return ch * ch_field_w(data_w);
    endfunction

    function automatic int unsigned mask_lsb(input int unsigned num_ch, input int unsigned data_w);
        return num_ch * ch_field_w(data_w);
    endfunction

    function automatic int unsigned ts_lsb(input int unsigned num_ch, input int unsigned data_w);
        return mask_lsb(num_ch, data_w) + num_ch;
    endfunction

    function automatic int unsigned entry_w(input int unsigned num_ch, input int unsigned data_w,
                                            input int unsigned ts_w);
        return ts_lsb(num_ch, data_w) + ts_w;
    endfunction

endpackage

// File: rtl/wb_trace_buffer_ram.sv
// Simple dual-port trace storage: one write port, one registered read port.
module trace_ram #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned WIDTH = 32,
    localparam int unsigned AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             re_i,
    input  logic [AW-1:0]    raddr_i,
    output logic [WIDTH-1:0] rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rdata_q;

    // Storage array write
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Read register holds its value until the next read enable
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/wb_trace_buffer.sv
// Writeback trace capture: trigger, circular buffer, oldest-first stream readout.
module wb_trace_buffer
    import wb_trace_pkg::*;
#(
    parameter int unsigned NUM_CH   = 2,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned DEPTH    = 16,
    parameter int unsigned TS_W     = 16,
    localparam int unsigned AW      = $clog2(DEPTH),
    localparam int unsigned CW      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    localparam int unsigned ENTRY_W = entry_w(NUM_CH, DATA_W, TS_W)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      arm,
    input  logic                      stop,
    input  logic                      mode,
    input  logic                      trig_en,
    input  logic [CW-1:0]             trig_ch,
    input  logic [4:0]                trig_rd,
    input  logic [DATA_W-1:0]         trig_data,
    input  logic [DATA_W-1:0]         trig_mask,
    input  logic [AW:0]               post_count,
    input  logic [NUM_CH-1:0]         ch_valid,
    input  logic [NUM_CH*5-1:0]       ch_rd,
    input  logic [NUM_CH*DATA_W-1:0]  ch_data,
    input  logic [NUM_CH*5-1:0]       ch_flags,
    input  logic                      rd_start,
    input  logic                      rd_ready,
    output logic                      rd_valid,
    output logic [ENTRY_W-1:0]        rd_data,
    output logic                      rd_last,
    output logic [2:0]                state,
    output logic [AW:0]               entry_count,
    output logic                      triggered,
    output logic                      overflow
);

    localparam int unsigned CH_FIELD_W = ch_field_w(DATA_W);
    localparam int unsigned MASK_LSB   = mask_lsb(NUM_CH, DATA_W);
    localparam int unsigned TS_LSB     = ts_lsb(NUM_CH, DATA_W);
    localparam int unsigned CNT_W      = AW + 1;
    localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] LAST_FREE = CNT_W'(DEPTH - 1);

    logic [ST_W-1:0]   state_q, state_d;
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [TS_W-1:0]   ts_q, ts_d;
    logic              triggered_q, triggered_d;
    logic              overflow_q, overflow_d;
    logic              mode_q, mode_d;
    logic [CNT_W-1:0]  post_q, post_d;
    logic [CNT_W-1:0]  left_q, left_d;
    logic              rd_valid_q, rd_valid_d;
    logic              rd_last_q, rd_last_d;

    logic [ENTRY_W-1:0] entry_c;
    logic               capturing_c;
    logic               wr_en_c;
    logic               trig_fire_c;
    logic               ram_re_c;
    logic               sel_valid_c;
    logic [RD_W-1:0]    sel_rd_c;
    logic [DATA_W-1:0]  sel_data_c;

    // Assemble one entry from all channels; invalid channels store zeros
    always_comb begin
        entry_c = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (ch_valid[c]) begin
                entry_c[ch_lsb(c, DATA_W) +: DATA_W]                  = ch_data[c*DATA_W +: DATA_W];
                entry_c[ch_lsb(c, DATA_W) + DATA_W +: FLAGS_W]        = ch_flags[c*FLAGS_W +: FLAGS_W];
                entry_c[ch_lsb(c, DATA_W) + DATA_W + FLAGS_W +: RD_W] = ch_rd[c*RD_W +: RD_W];
            end
        end
        entry_c[MASK_LSB +: NUM_CH] = ch_valid;
        entry_c[TS_LSB +: TS_W]     = ts_q;
    end

    // Select the trigger channel's writeback fields
    always_comb begin
        sel_valid_c = 1'b0;
        sel_rd_c    = '0;
        sel_data_c  = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (trig_ch == CW'(c)) begin
                sel_valid_c = ch_valid[c];
                sel_rd_c    = ch_rd[c*RD_W +: RD_W];
                sel_data_c  = ch_data[c*DATA_W +: DATA_W];
            end
        end
    end

    assign capturing_c = (state_q == ST_CAPTURE) || (state_q == ST_POST);
    assign wr_en_c     = capturing_c && (|ch_valid) && !arm;
    // Only CAPTURE can fire, so later matches in POST are ignored
    assign trig_fire_c = (state_q == ST_CAPTURE) && trig_en && sel_valid_c &&
                         (sel_rd_c == trig_rd) &&
                         (((sel_data_c ^ trig_data) & trig_mask) == '0);

    // FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic; arm overrides everything
    always_comb begin
        state_d = state_q;
        if (arm) begin
            state_d = ST_CAPTURE;
        end else begin
            case (state_q)
                ST_CAPTURE: begin
                    if (stop) begin
                        state_d = ST_DONE;
                    end else if (wr_en_c) begin
                        if (mode_q && (count_q == LAST_FREE)) begin
                            state_d = ST_DONE;
                        end else if (trig_fire_c) begin
                            state_d = (post_q == '0) ? ST_DONE : ST_POST;
                        end
                    end
                end
                ST_POST: begin
                    if (stop) begin
                        state_d = ST_DONE;
                    end else if (wr_en_c) begin
                        if (mode_q && (count_q == LAST_FREE)) begin
                            state_d = ST_DONE;
                        end else if (left_q == CNT_W'(1)) begin
                            state_d = ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    if (rd_start) begin
                        state_d = (count_q != '0) ? ST_READOUT : ST_IDLE;
                    end
                end
                ST_READOUT: begin
                    if (rd_valid_q && rd_ready && rd_last_q) begin
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Datapath next values: pointers, counts, trigger bookkeeping, read stream
    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        ts_d        = ts_q;
        triggered_d = triggered_q;
        overflow_d  = overflow_q;
        mode_d      = mode_q;
        post_d      = post_q;
        left_d      = left_q;
        rd_valid_d  = rd_valid_q;
        rd_last_d   = rd_last_q;
        ram_re_c    = 1'b0;

        if (arm) begin
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            count_d     = '0;
            ts_d        = '0;
            triggered_d = 1'b0;
            overflow_d  = 1'b0;
            mode_d      = mode;
            // In wrap mode the trigger entry must not be overwritten by its own tail
            post_d      = (!mode && (post_count > LAST_FREE)) ? LAST_FREE : post_count;
            left_d      = '0;
            rd_valid_d  = 1'b0;
            rd_last_d   = 1'b0;
        end else begin
            if (capturing_c) begin
                ts_d = ts_q + TS_W'(1);
            end
            if (wr_en_c) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
                if (count_q == FULL_CNT) begin
                    rd_ptr_d   = rd_ptr_q + AW'(1);
                    overflow_d = 1'b1;
                end else begin
                    count_d = count_q + CNT_W'(1);
                end
                if (trig_fire_c) begin
                    triggered_d = 1'b1;
                    left_d      = post_q;
                end else if (state_q == ST_POST) begin
                    left_d = left_q - CNT_W'(1);
                end
            end
            if ((state_q == ST_READOUT) && (!rd_valid_q || rd_ready)) begin
                if (count_q != '0) begin
                    ram_re_c   = 1'b1;
                    rd_ptr_d   = rd_ptr_q + AW'(1);
                    count_d    = count_q - CNT_W'(1);
                    rd_valid_d = 1'b1;
                    rd_last_d  = (count_q == CNT_W'(1));
                end else begin
                    rd_valid_d = 1'b0;
                    rd_last_d  = 1'b0;
                end
            end
        end
    end

    // Datapath registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            ts_q        <= '0;
            triggered_q <= 1'b0;
            overflow_q  <= 1'b0;
            mode_q      <= 1'b0;
            post_q      <= '0;
            left_q      <= '0;
            rd_valid_q  <= 1'b0;
            rd_last_q   <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            ts_q        <= ts_d;
            triggered_q <= triggered_d;
            overflow_q  <= overflow_d;
            mode_q      <= mode_d;
            post_q      <= post_d;
            left_q      <= left_d;
            rd_valid_q  <= rd_valid_d;
            rd_last_q   <= rd_last_d;
        end
    end

    trace_ram #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_ram (
        .clk     (clk),
        .reset   (reset),
        .we_i    (wr_en_c),
        .waddr_i (wr_ptr_q),
        .wdata_i (entry_c),
        .re_i    (ram_re_c),
        .raddr_i (rd_ptr_q),
        .rdata_o (rd_data)
    );

    assign rd_valid    = rd_valid_q;
    assign rd_last     = rd_last_q;
    assign state       = state_q;
    assign entry_count = count_q;
    assign triggered   = triggered_q;
    assign overflow    = overflow_q;

endmodule

// File: doc/wb_trace_buffer.md
Name: wb_trace_buffer

Overview:
- Synthesizable writeback trace capture for the RV32IF pipeline; the on-chip successor to the simulation-only pipeline monitor.
- Records writeback events from NUM_CH channels (default: int WB, FP WB) into a circular buffer of DEPTH entries, with cycle timestamps.
- Supports a programmable trigger with post-trigger count, wrap or stop-when-full mode, and oldest-first readout over a valid/ready stream.
- Sits beside RISC_V_RV32F_PROCESSOR_POWER_OPT and is fed from its wb_* signals.

Parameters:
- NUM_CH, 2, number of writeback channels traced.
- DATA_W, 32, width of data per channel.
- DEPTH, 16, number of buffer entries; must be a power of 2, at least 4.
- TS_W, 16, timestamp width.
- Derived: AW = log2(DEPTH); CW = max(1, log2(NUM_CH)); ENTRY_W = TS_W + NUM_CH + NUM_CH*(10+DATA_W).

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- arm  in  1  pulse; clears the buffer and starts capture
- stop  in  1  pulse; forces DONE from CAPTURE/POST
- mode  in  1  0 = wrap (overwrite oldest), 1 = stop-when-full; sampled on arm
- trig_en  in  1  enables the trigger compare
- trig_ch  in  CW  channel the trigger compares on
- trig_rd  in  5  destination register to match
- trig_data  in  DATA_W  data value to match
- trig_mask  in  DATA_W  data bits that take part in the compare
- post_count  in  AW+1  entries to store after the trigger entry; sampled on arm
- ch_valid  in  NUM_CH  writeback valid, one bit per channel
- ch_rd  in  NUM_CH*5  destination register per channel
- ch_data  in  NUM_CH*DATA_W  writeback data per channel
- ch_flags  in  NUM_CH*5  FP flags per channel (0 for the int channel)
- rd_start  in  1  starts readout from DONE
- rd_ready  in  1  consumer ready
- rd_valid  out  1  rd_data is valid
- rd_data  out  ENTRY_W  {timestamp, valid mask, per-channel {rd, flags, data}}; channel 0 in the LSBs
- rd_last  out  1  final entry of the readout
- state  out  3  current FSM state
- entry_count  out  AW+1  entries currently held
- triggered  out  1  sticky; trigger has fired since arm
- overflow  out  1  sticky; an entry was overwritten or dropped

Behaviour:
- Reset: all outputs 0; state IDLE; pointers, timestamp and counts 0. Reset mid-capture or mid-readout discards everything.
- States and transitions:
  - IDLE=0: -> CAPTURE on arm.
  - CAPTURE=1: -> POST on trigger; -> DONE on stop; -> DONE when full with mode=1.
  - POST=2: -> DONE after post_count further entries, or on stop.
  - DONE=3: -> READOUT on rd_start with entry_count>0; rd_start with entry_count=0 -> IDLE.
  - READOUT=4: -> IDLE after the handshake on the rd_last entry.
- arm in any state: clears pointers, counts, triggered, overflow and timestamp, then -> CAPTURE next cycle. arm has priority over rd_start and stop.
- Timestamp: zeroed on arm; +1 every cycle in CAPTURE/POST; wraps at 2^TS_W.
- Write rule:
  - In CAPTURE/POST, any edge with |ch_valid writes one entry holding all channels and the valid mask. Invalid channel fields are stored as 0.
  - Write lands at that edge; entry_count updates the same edge.
- Full condition:
  - mode=0: write overwrites the oldest entry, read pointer advances, overflow=1, entry_count saturates at DEPTH.
  - mode=1: the entry that fills the buffer is written, then -> DONE; overflow=0. If a trigger arrives on that same entry, triggered=1 still.
- Trigger:
  - Fires when trig_en & ch_valid[trig_ch] & ch_rd[trig_ch]==trig_rd & ((ch_data[trig_ch]^trig_data)&trig_mask)==0.
  - The trigger entry is stored; triggered=1 the same edge.
  - Only the first match counts; later matches in POST are ignored.
  - post_count=0 -> DONE on the trigger edge.
  - In mode 0, post_count is clamped to DEPTH-1 so the trigger entry survives.
- Readout:
  - Synchronous RAM read; first rd_valid appears 1 cycle after entering READOUT.
  - Entries come out oldest first. rd_data and rd_last hold stable while rd_valid & !rd_ready.
  - Each handshake presents the next entry; no bubble is required, one bubble is allowed.
  - After the last handshake: rd_valid=0, entry_count=0. Capture inputs are ignored during DONE and READOUT.

Decomposition:
- Package wb_trace_pkg holds:
  - state encoding constants ST_IDLE..ST_READOUT;
  - per-channel field width CH_FIELD_W = 10+DATA_W;
  - entry field offset functions.
- Sub-module trace_ram: simple dual-port memory, DEPTH x ENTRY_W, one write port, registered read port.
- Top level: FSM, pointers, counters, trigger compare, output register.

Test Plan (NUM_CH=2, DEPTH=8, TS_W=16):
1. Assert reset mid-capture after 5 events -> next cycle state=0, entry_count=0, rd_valid=0, overflow=0, triggered=0.
2. mode=0, trig_en=0; 12 ch0 events rd=1..12 on consecutive cycles; then stop, rd_start, rd_ready=1 -> entry_count=8, overflow=1; readout rd=5..12, rd_last on rd=12, then state=0.
3. mode=1; 10 events -> DONE after the 8th, entry_count=8, overflow=0; readout rd=1..8.
4. Trigger trig_ch=1, trig_rd=4, trig_data=0x40A00000, mask=0xFFFFFFFF, post_count=2; FP events f1..f6 with f4=0x40A00000 -> triggered=1, DONE after f6, readout ends with f4, f5, f6.
5. ch0 rd=10 and ch1 rd=2 valid in the same cycle -> single entry, mask=2'b11, both fields correct, timestamp increments by the cycle gap between entries.
6. During readout, rd_ready low 3 cycles -> rd_data stable; arm asserted mid-readout -> rd_valid=0 next cycle, state=1, entry_count=0.
